unit_access_arbiter: RTL and testbench

Shares the unit address decoder's target-side bus (one-hot sel_en_out, wr_rd_s_out, addr_out, wr_data_out, ack_in, rd_data_in) between NUM_MST requesters. It arbitrates round-robin and decodes the address to a target. It drives one transaction at a time, waits for the selected target's ack with a timeout, and returns completion, error and read data to the granted requester.

---
 rtl/unit_access_arbiter.sv | 133 +++++++++++++
 tb/tb_unit_access_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/unit_access_arbiter.sv
// Round-robin access arbiter in front of the unit address decoder's target bus.
// One transaction at a time: grant, select decoded target, await ack or timeout, report.
module unit_access_arbiter #(
  parameter int NUM_MST = 4,
  parameter int NUM_TGT = 5,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_MST-1:0]        req,
  input  logic [NUM_MST-1:0]        wr_rd_s,
  input  logic [NUM_MST*ADDR_W-1:0] addr,
  input  logic [NUM_MST*DATA_W-1:0] wr_data,
  output logic [NUM_MST-1:0]        gnt,
  output logic [NUM_MST-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rd_data_out,
  output logic [NUM_TGT-1:0]        sel_en_out,
  output logic                      wr_rd_s_out,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [DATA_W-1:0]         wr_data_out,
  input  logic [NUM_TGT-1:0]        ack_in,
  input  logic [DATA_W-1:0]         rd_data_in
);

  localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [CW-1:0]       cnt;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic [ADDR_W-1:0]   win_addr;
  logic [2:0]          tidx;
  logic                dec_ok;
  logic [NUM_TGT-1:0]  tgt_onehot;
  logic                ack_hit;

  // Search starts one past the last winner, so the previous winner is served last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_MST; i++) begin
      cand = PW'((32'(ptr) + i) % 32'(NUM_MST));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr   = addr[win_idx*ADDR_W +: ADDR_W];
    tidx       = win_addr[ADDR_W-1 -: 3];
    dec_ok     = (int'(tidx) < NUM_TGT);
    tgt_onehot = dec_ok ? (NUM_TGT'(1) << tidx) : '0;
    ack_hit    = |(ack_in & sel_en_out);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_MST - 1);
      gidx        <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rd_data_out <= '0;
      sel_en_out  <= '0;
      wr_rd_s_out <= 1'b0;
      addr_out    <= '0;
      wr_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt         <= NUM_MST'(1) << win_idx;
            gidx        <= win_idx;
            wr_rd_s_out <= wr_rd_s[win_idx];
            addr_out    <= win_addr;
            wr_data_out <= wr_data[win_idx*DATA_W +: DATA_W];
            if (dec_ok) begin
              sel_en_out <= tgt_onehot;
              cnt        <= '0;
              state      <= ACCESS;
            end else begin
              // Decode error skips the target entirely; done goes out with the grant.
              done  <= NUM_MST'(1) << win_idx;
              err   <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            sel_en_out <= '0;
            done       <= gnt;
            err        <= 1'b0;
            if (!wr_rd_s_out) rd_data_out <= rd_data_in;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            sel_en_out  <= '0;
            done        <= gnt;
            err         <= 1'b1;
            rd_data_out <= '0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          ptr   <= gidx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_access_arbiter.sv
// Directed bench for unit_access_arbiter; completions are checked against a scoreboard
// of expected (requester, err, read data) entries pushed when each request is driven.
module tb_unit_access_arbiter;

  localparam int NUM_MST = 4;
  localparam int NUM_TGT = 5;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_MST-1:0]        req;
  logic [NUM_MST-1:0]        wr_rd_s;
  logic [NUM_MST*ADDR_W-1:0] addr;
  logic [NUM_MST*DATA_W-1:0] wr_data;
  logic [NUM_MST-1:0]        gnt;
  logic [NUM_MST-1:0]        done;
  logic                      err;
  logic [DATA_W-1:0]         rd_data_out;
  logic [NUM_TGT-1:0]        sel_en_out;
  logic                      wr_rd_s_out;
  logic [ADDR_W-1:0]         addr_out;
  logic [DATA_W-1:0]         wr_data_out;
  logic [NUM_TGT-1:0]        ack_in;
  logic [DATA_W-1:0]         rd_data_in;

  typedef struct {
    int unsigned mst;
    logic        err;
    logic        chk_rd;
    logic [7:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  int   ncyc;

  unit_access_arbiter #(
    .NUM_MST(NUM_MST), .NUM_TGT(NUM_TGT), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wr_rd_s(wr_rd_s),
    .addr(addr), .wr_data(wr_data), .gnt(gnt), .done(done), .err(err),
    .rd_data_out(rd_data_out), .sel_en_out(sel_en_out), .wr_rd_s_out(wr_rd_s_out),
    .addr_out(addr_out), .wr_data_out(wr_data_out), .ack_in(ack_in),
    .rd_data_in(rd_data_in)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_txn(input int unsigned m, input logic e, input logic c, input logic [7:0] r);
    exp_t x;
    x.mst = m; x.err = e; x.chk_rd = c; x.rd = r;
    sb.push_back(x);
  endtask

  // Completion monitor on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset_n && done != '0) begin
      chk("done_onehot", 32'($onehot(done)), 32'd1);
      chk("done_without_gnt", 32'(done & ~gnt), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_x = sb.pop_front();
        chk("sb_done_idx", 32'(done), 32'd1 << mon_x.mst);
        chk("sb_err", 32'(err), 32'(mon_x.err));
        if (mon_x.chk_rd) chk("sb_rd_data", 32'(rd_data_out), 32'(mon_x.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; req = '0; wr_rd_s = '0; addr = '0; wr_data = '0;
    ack_in = '0; rd_data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sel", 32'(sel_en_out), 32'd0);
    chk("rst_rd", 32'(rd_data_out), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single read to target 2, ack on the third select cycle
    req = 4'b0001; wr_rd_s = 4'b0000; addr[0 +: 8] = 8'h45;
    expect_txn(0, 1'b0, 1'b1, 8'hA5);
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_sel1", 32'(sel_en_out), 32'h04);
    chk("rd_addr_out", 32'(addr_out), 32'h45);
    chk("rd_dir_out", 32'(wr_rd_s_out), 32'd0);
    req = '0;
    tick();
    chk("rd_sel2", 32'(sel_en_out), 32'h04);
    tick();
    chk("rd_sel3", 32'(sel_en_out), 32'h04);
    ack_in = 5'b00100; rd_data_in = 8'hA5;
    tick();
    chk("rd_sel_drop", 32'(sel_en_out), 32'd0);
    chk("rd_done", 32'(done), 32'h1);
    chk("rd_err", 32'(err), 32'd0);
    chk("rd_data", 32'(rd_data_out), 32'hA5);
    ack_in = '0;
    tick();
    chk("rd_done_clr", 32'(done), 32'd0);
    chk("rd_gnt_clr", 32'(gnt), 32'd0);

    // Fresh pointer, then round-robin with all requesters held and zero-wait acks
    reset_n = 1'b0; #3; reset_n = 1'b1;
    for (int k = 0; k < NUM_MST; k++) addr[k*8 +: 8] = {3'(k), 5'h01};
    wr_rd_s = '0; req = 4'hF; ack_in = '1;
    for (int t = 0; t < 5; t++) begin
      rd_data_in = 8'h10 + 8'(t);
      expect_txn(t % 4, 1'b0, 1'b1, 8'h10 + 8'(t));
      tick();
      chk("rr_gnt", 32'(gnt), 32'd1 << (t % 4));
      chk("rr_sel", 32'(sel_en_out), 32'd1 << (t % 4));
      tick();
      chk("rr_done", 32'(done), 32'd1 << (t % 4));
      if (t == 4) req = '0;
      tick();
    end
    ack_in = '0;

    // Decode error: target index 7
    req = 4'b0010; addr[8 +: 8] = 8'hE0;
    expect_txn(1, 1'b1, 1'b0, 8'h00);
    tick();
    chk("dec_gnt", 32'(gnt), 32'h2);
    chk("dec_done", 32'(done), 32'h2);
    chk("dec_err", 32'(err), 32'd1);
    chk("dec_sel", 32'(sel_en_out), 32'd0);
    req = '0;
    tick();
    chk("dec_idle", 32'({gnt, done, err}), 32'd0);

    // Timeout on a write; a stray ack for another target must be ignored
    req = 4'b0100; wr_rd_s = 4'b0100; addr[16 +: 8] = 8'h20; wr_data[16 +: 8] = 8'h5A;
    expect_txn(2, 1'b1, 1'b1, 8'h00);
    tick();
    chk("to_sel", 32'(sel_en_out), 32'h02);
    chk("to_dir_out", 32'(wr_rd_s_out), 32'd1);
    chk("to_wdata_out", 32'(wr_data_out), 32'h5A);
    req = '0; wr_rd_s = '0; addr[16 +: 8] = 8'hFF;
    ncyc = 1;
    for (int i = 0; i < 40; i++) begin
      ack_in = (ncyc == 5) ? 5'b01000 : 5'b00000;
      tick();
      if (sel_en_out == '0) break;
      ncyc++;
    end
    ack_in = '0;
    chk("to_sel_cycles", 32'(ncyc), 32'(TIMEOUT));
    chk("to_done", 32'(done), 32'h4);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rd_zero", 32'(rd_data_out), 32'd0);
    chk("to_addr_held", 32'(addr_out), 32'h20);
    tick();

    // Ack arriving on the final select cycle beats the timeout
    req = 4'b0010; addr[8 +: 8] = 8'h20;
    expect_txn(1, 1'b0, 1'b1, 8'h3C);
    tick();
    req = '0;
    repeat (TIMEOUT - 1) tick();
    chk("col_sel_last", 32'(sel_en_out), 32'h02);
    ack_in = 5'b00010; rd_data_in = 8'h3C;
    tick();
    chk("col_done", 32'(done), 32'h2);
    chk("col_err", 32'(err), 32'd0);
    chk("col_rd", 32'(rd_data_out), 32'h3C);
    chk("col_sel", 32'(sel_en_out), 32'd0);
    ack_in = '0;
    tick();

    // Asynchronous reset in the middle of an access
    req = 4'b0001; addr[0 +: 8] = 8'h20;
    tick();
    chk("ar_gnt", 32'(gnt), 32'h1);
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_sel", 32'(sel_en_out), 32'd0);
    chk("ar_gnt_clr", 32'(gnt), 32'd0);
    chk("ar_rd", 32'(rd_data_out), 32'd0);
    chk("ar_addr_out", 32'(addr_out), 32'd0);
    reset_n = 1'b1;
    addr[0 +: 8] = 8'h00; addr[16 +: 8] = 8'h00;
    req = 4'b0101; ack_in = '1; rd_data_in = 8'h77;
    expect_txn(0, 1'b0, 1'b1, 8'h77);
    expect_txn(2, 1'b0, 1'b1, 8'h77);
    tick();
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    repeat (3) tick();
    chk("ar_second_gnt", 32'(gnt), 32'h4);
    req = '0;
    repeat (3) tick();
    ack_in = '0;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
